decimal_entry: RTL
==================

Name: decimal_entry

Overview:
- Digit-entry accumulator; the inverse of the binary-to-tens/ones display converter.
- Accepts decimal digits one at a time from the keypad/button front end and builds a 2-digit value.
- Drives live tens/ones display codes, using the same blank convention as the display path (code 10 = blank).
- On commit, emits a 7-bit binary value (0..MAX_VALUE) with a 1-cycle valid pulse for downstream counters/comparators.

Parameters:
- MAX_VALUE, 99, largest committable value (1..99); e.g. 59 for minute entry.
- TIMEOUT_CYCLES, 50_000_000, idle cycles before auto-commit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digit  in  4  decimal digit 0..9.
- digit_valid  in  1  1-cycle strobe; digit is sampled when high.
- backspace  in  1  1-cycle strobe; removes the last digit.
- enter  in  1  1-cycle strobe; commits the entry.
- clear  in  1  1-cycle strobe; discards the entry.
- ten  out  4  display tens code; 0..9, or 10 = blank.
- one  out  4  display ones code; 0..9, or 10 = blank.
- n  out  7  last committed binary value.
- n_valid  out  1  1-cycle pulse when n is updated.
- err  out  1  1-cycle pulse on a rejected action.

Behaviour:
- Reset: state EMPTY; tens_r=0; ones_r=0; n=0; n_valid=0; err=0; ten=10; one=10.
- All outputs are registered. Effects appear in the cycle after the strobe is sampled.
- States:
  - EMPTY: no digits held.
  - ONE: ones_r valid.
  - TWO: tens_r and ones_r valid.
- Strobe priority within one cycle: clear > enter > backspace > digit_valid.
  - Lower-priority strobes are dropped silently; no err.
- clear: any state -> EMPTY. No n_valid, no err.
- enter:
  - ONE or TWO: n <= tens_r*10+ones_r (tens_r is 0 in ONE); n_valid=1 for one cycle; -> EMPTY.
  - EMPTY: err pulse; state unchanged.
- backspace:
  - TWO -> ONE with ones_r <= tens_r.
  - ONE -> EMPTY.
  - EMPTY: ignored, no err.
- digit_valid with digit > 9: err pulse; no state change.
- digit_valid in EMPTY:
  - If d > MAX_VALUE: err.
  - Otherwise ones_r <= d; -> ONE.
- digit_valid in ONE:
  - If ones_r == 0 (leading zero): ones_r <= d, stay ONE; same MAX_VALUE check.
  - Else candidate = ones_r*10+d. If candidate <= MAX_VALUE: tens_r <= ones_r, ones_r <= d, -> TWO. Otherwise err, no change.
- digit_valid in TWO: full; err pulse; no change.
- Display mapping:
  - EMPTY: ten=10, one=10.
  - ONE: ten=10, one=ones_r.
  - TWO: ten=tens_r, one=ones_r.
- Arithmetic: x*10 computed as (x<<3)+(x<<1) in 7 bits. No overflow, since values are <= 99.
- n holds its value between commits. n_valid and err are never asserted in the same cycle.
- Reset asserted mid-entry returns all outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro: DECIMAL_ENTRY_TIMEOUT_EN.
- Defined:
  - A 26-bit idle counter clears on any accepted or rejected strobe and while in EMPTY.
  - In ONE/TWO, when the counter reaches TIMEOUT_CYCLES-1, an implicit enter occurs: commit, n_valid pulse, -> EMPTY.
  - A real strobe arriving in the timeout cycle takes precedence; the counter restarts.
- Undefined: no counter; an entry is held indefinitely.

Decomposition:
- Package decimal_pkg:
  - state typedef {EMPTY, ONE, TWO}.
  - BLANK_CODE=4'd10.
  - DIGIT_W=4, VALUE_W=7.
- Sub-module digit_pair_to_bin: combinational tens/ones -> 7-bit binary via shift-add. Shared by the candidate check and the commit path.

Test Plan:
- Reset, then digits 4,2, then enter -> ten/one show 10/4, then 4/2; n=42 with n_valid high exactly 1 cycle; ten/one return to 10/10.
- Digits 0,7, then enter -> display 10/0 then 10/7 (leading zero replaced); n=7.
- MAX_VALUE=59: digits 6 then 1 -> after 6, display 10/6; 1 is rejected with err pulse (61>59); enter gives n=6.
- Digits 1,2,3 -> third digit gives err; backspace -> display 10/1; digit 5, enter -> n=15.
- enter in EMPTY -> err pulse, n unchanged. clear and enter in the same cycle with 1 digit held -> EMPTY, no n_valid, no err.
- With DECIMAL_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: digit 9, then idle -> n=9 and n_valid exactly 16 cycles after the digit is accepted. rst_n low mid-entry -> immediate 10/10, n=0.

Source files
------------

// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal digit-entry block.
package decimal_pkg;

  localparam int DIGIT_W = 4;
  localparam int VALUE_W = 7;

  // Display code that turns a digit position off.
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'd10;

  // Number of digits currently held by the entry buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/decimal_entry_digit_pair_to_bin.sv
// Combinational tens/ones digit pair to 7-bit binary, x*10 done as shift-add.
import decimal_pkg::*;

module digit_pair_to_bin (
  input  logic [DIGIT_W-1:0] tens_i,
  input  logic [DIGIT_W-1:0] ones_i,
  output logic [VALUE_W-1:0] value_o
);

  logic [VALUE_W-1:0] tens_ext;
  logic [VALUE_W-1:0] ones_ext;

  assign tens_ext = {3'b000, tens_i};
  assign ones_ext = {3'b000, ones_i};

  // tens*10 + ones; inputs are decimal digits so the sum never exceeds 99.
  assign value_o = (tens_ext << 3) + (tens_ext << 1) + ones_ext;

endmodule

// File: rtl/decimal_entry.sv
// Decimal digit-entry accumulator: builds a 2-digit value from keypad
// strobes, drives live tens/ones display codes and commits a binary value.
// Optional idle auto-commit is compiled in with DECIMAL_ENTRY_TIMEOUT_EN.
//
// Strobe handshake: digit_valid, backspace, enter and clear are single-cycle
// requests with no back-pressure; each is consumed in the cycle it is high.
// When several are high together only the highest priority one acts
// (clear > enter > backspace > digit_valid); the rest are dropped silently.
import decimal_pkg::*;

module decimal_entry #(
  parameter int MAX_VALUE      = 99,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_valid,
  input  logic               backspace,
  input  logic               enter,
  input  logic               clear,
  output logic [DIGIT_W-1:0] ten,
  output logic [DIGIT_W-1:0] one,
  output logic [VALUE_W-1:0] n,
  output logic               n_valid,
  output logic               err,
  output state_t             state_o
);

  localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [DIGIT_W-1:0] ten_q, ten_d;
  logic [DIGIT_W-1:0] one_q, one_d;
  logic [VALUE_W-1:0] n_q, n_d;
  logic               n_valid_q, n_valid_d;
  logic               err_q, err_d;

  logic [VALUE_W-1:0] commit_value;
  logic [VALUE_W-1:0] candidate;
  logic [VALUE_W-1:0] digit_ext;
  logic               digit_bad;

  assign digit_ext = {3'b000, digit};
  assign digit_bad = (digit > 4'd9);

  // Value committed on enter: tens_q is zero while only one digit is held.
  digit_pair_to_bin u_commit_conv (
    .tens_i  (tens_q),
    .ones_i  (ones_q),
    .value_o (commit_value)
  );

  // Value the entry would become if the incoming digit were appended.
  digit_pair_to_bin u_cand_conv (
    .tens_i  (ones_q),
    .ones_i  (digit),
    .value_o (candidate)
  );

`ifdef DECIMAL_ENTRY_TIMEOUT_EN
  localparam logic [25:0] IDLE_LAST = 26'(TIMEOUT_CYCLES - 1);

  logic [25:0] idle_q, idle_d;
  logic        strobe_any;
  logic        timeout_hit;

  assign strobe_any  = digit_valid | backspace | enter | clear;
  assign timeout_hit = (state_q != EMPTY) && (idle_q == IDLE_LAST);

  // Idle counter runs only while a partial entry is held and nothing is pressed.
  always_comb begin
    idle_d = idle_q + 26'd1;
    if (strobe_any || (state_q == EMPTY)) begin
      idle_d = '0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  // Next-state, digit buffer, commit and error decode in strobe priority order.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    n_d       = n_q;
    n_valid_d = 1'b0;
    err_d     = 1'b0;

    if (clear) begin
      state_d = EMPTY;
      tens_d  = '0;
      ones_d  = '0;
    end else if (enter) begin
      if (state_q == EMPTY) begin
        err_d = 1'b1;
      end else begin
        n_d       = commit_value;
        n_valid_d = 1'b1;
        state_d   = EMPTY;
        tens_d    = '0;
        ones_d    = '0;
      end
    end else if (backspace) begin
      case (state_q)
        TWO: begin
          state_d = ONE;
          ones_d  = tens_q;
          tens_d  = '0;
        end
        ONE: begin
          state_d = EMPTY;
          ones_d  = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (digit_valid) begin
      if (digit_bad) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          EMPTY: begin
            if (digit_ext > MAX_V) begin
              err_d = 1'b1;
            end else begin
              state_d = ONE;
              tens_d  = '0;
              ones_d  = digit;
            end
          end
          ONE: begin
            if (ones_q == 4'd0) begin
              // A held leading zero is simply replaced.
              if (digit_ext > MAX_V) begin
                err_d = 1'b1;
              end else begin
                ones_d = digit;
              end
            end else if (candidate <= MAX_V) begin
              state_d = TWO;
              tens_d  = ones_q;
              ones_d  = digit;
            end else begin
              err_d = 1'b1;
            end
          end
          default: begin
            // Two digits already held: no room.
            err_d = 1'b1;
          end
        endcase
      end
    end
`ifdef DECIMAL_ENTRY_TIMEOUT_EN
    else if (timeout_hit) begin
      n_d       = commit_value;
      n_valid_d = 1'b1;
      state_d   = EMPTY;
      tens_d    = '0;
      ones_d    = '0;
    end
`endif

    ten_d = (state_d == TWO)   ? tens_d     : BLANK_CODE;
    one_d = (state_d == EMPTY) ? BLANK_CODE : ones_d;
  end

  // State, digit buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      tens_q    <= '0;
      ones_q    <= '0;
      ten_q     <= BLANK_CODE;
      one_q     <= BLANK_CODE;
      n_q       <= '0;
      n_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      ten_q     <= ten_d;
      one_q     <= one_d;
      n_q       <= n_d;
      n_valid_q <= n_valid_d;
      err_q     <= err_d;
    end
  end

  assign ten     = ten_q;
  assign one     = one_q;
  assign n       = n_q;
  assign n_valid = n_valid_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule
